cdr_phase_selector: RTL and testbench

//  Consumer of the early/late votes from the 16-phase detector. Synchronises the

---
 rtl/cdr_phase_selector.sv | 136 +++++++++++++
 tb/tb_cdr_phase_selector.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cdr_phase_selector.sv
// cdr_phase_selector: synchronises early/late votes, filters them and steps a
// wrap-around sampling-phase pointer with lock detection.  Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module cdr_phase_selector #(
  parameter int NPHASE      = 16,
  parameter int PTR_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int THRESH      = 8,
  parameter int HOLDOFF     = 4,
  parameter int LOCK_CYC    = 64,
  parameter int INIT_PHASE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              shift_left,
  input  logic              shift_right,
  output logic [PTR_W-1:0]  phase_idx,
  output logic [NPHASE-1:0] phase_sel,
  output logic              step_left,
  output logic              step_right,
  output logic              locked
);

  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int LOCK_W = $clog2(LOCK_CYC + 1);
  localparam logic signed [7:0] ACC_MAX = 8'(THRESH - 1);
  localparam logic signed [7:0] ACC_MIN = 8'(1 - THRESH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                   state, state_nxt;
  logic [SYNC_STAGES-1:0]   sl_pipe, sr_pipe;
  logic signed [7:0]        acc, acc_nxt;
  logic [HOLD_W-1:0]        hold_cnt, hold_nxt;
  logic [LOCK_W-1:0]        lock_cnt, lock_nxt;
  logic [PTR_W-1:0]         idx_nxt;
  logic [NPHASE-1:0]        sel_nxt;
  logic                     step_l_nxt, step_r_nxt, locked_nxt;
  logic                     sl, sr, vote_up, vote_dn, do_up, do_dn;

  assign sl      = sl_pipe[SYNC_STAGES-1];
  assign sr      = sr_pipe[SYNC_STAGES-1];
  assign vote_up = sr & ~sl;
  assign vote_dn = sl & ~sr;

  // Synchronisers run regardless of en; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sl_pipe <= '0;
      sr_pipe <= '0;
    end else begin
      sl_pipe <= {sl_pipe[SYNC_STAGES-2:0], shift_left};
      sr_pipe <= {sr_pipe[SYNC_STAGES-2:0], shift_right};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      hold_cnt   <= '0;
      lock_cnt   <= '0;
      phase_idx  <= PTR_W'(INIT_PHASE);
      phase_sel  <= NPHASE'(1) << INIT_PHASE;
      step_left  <= 1'b0;
      step_right <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      hold_cnt   <= hold_nxt;
      lock_cnt   <= lock_nxt;
      phase_idx  <= idx_nxt;
      phase_sel  <= sel_nxt;
      step_left  <= step_l_nxt;
      step_right <= step_r_nxt;
      locked     <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    hold_nxt   = hold_cnt;
    lock_nxt   = lock_cnt;
    idx_nxt    = phase_idx;
    step_l_nxt = 1'b0;
    step_r_nxt = 1'b0;
    locked_nxt = locked;
    do_up      = 1'b0;
    do_dn      = 1'b0;

    if (en) begin
      case (state)
        S_IDLE: begin
          if (vote_up && acc == ACC_MAX)      do_up = 1'b1;
          else if (vote_dn && acc == ACC_MIN) do_dn = 1'b1;
          else if (vote_up)                   acc_nxt = acc + 8'sd1;
          else if (vote_dn)                   acc_nxt = acc - 8'sd1;
        end
        S_HOLD: begin
          acc_nxt  = '0;
          hold_nxt = hold_cnt - 1'b1;
          if (hold_cnt == HOLD_W'(1)) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase

      if (do_up || do_dn) begin
        acc_nxt    = '0;
        hold_nxt   = HOLD_W'(HOLDOFF);
        state_nxt  = (HOLDOFF > 0) ? S_HOLD : S_IDLE;
        lock_nxt   = '0;
        locked_nxt = 1'b0;
        step_r_nxt = do_up;
        step_l_nxt = do_dn;
        if (do_up)
          idx_nxt = (phase_idx == PTR_W'(NPHASE - 1)) ? '0 : phase_idx + 1'b1;
        else
          idx_nxt = (phase_idx == '0) ? PTR_W'(NPHASE - 1) : phase_idx - 1'b1;
      end else begin
        lock_nxt   = (lock_cnt == LOCK_W'(LOCK_CYC)) ? lock_cnt : lock_cnt + 1'b1;
        locked_nxt = (lock_nxt == LOCK_W'(LOCK_CYC));
      end
    end

    sel_nxt          = '0;
    sel_nxt[idx_nxt] = 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_cdr_phase_selector.sv
// Scoreboard bench for cdr_phase_selector: stimulus queues expected step events,
// a monitor pops and compares them whenever a step pulse appears.
`default_nettype none
`timescale 1ns/1ps

module tb_cdr_phase_selector;

  logic        clk = 1'b0;
  logic        rst, en, shift_left, shift_right;
  logic [3:0]  phase_idx;
  logic [15:0] phase_sel;
  logic        step_left, step_right, locked;

  cdr_phase_selector #(
    .NPHASE(16), .PTR_W(4), .SYNC_STAGES(2), .THRESH(8),
    .HOLDOFF(4), .LOCK_CYC(64), .INIT_PHASE(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .shift_left(shift_left), .shift_right(shift_right),
    .phase_idx(phase_idx), .phase_sel(phase_sel),
    .step_left(step_left), .step_right(step_right), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit right;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int at, input bit right, input int idx);
    exp_q.push_back('{cyc: at, right: right, idx: idx});
  endtask

  // Monitor: counts edges and scores every step pulse against the queue.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (step_left || step_right) begin
      check("step_exclusive", int'(step_left && step_right), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step actual=L%0d/R%0d required=none cyc=%0d",
                 step_left, step_right, cyc);
      end else begin
        e_mon = exp_q.pop_front();
        check("step_cycle", cyc, e_mon.cyc);
        check("step_dir_right", int'(step_right), int'(e_mon.right));
        check("step_idx", int'(phase_idx), e_mon.idx);
        check("step_sel", int'(phase_sel), 1 << e_mon.idx);
        check("step_locked_clear", int'(locked), 0);
      end
    end
  end

  int base;

  initial begin
    rst = 1'b1; en = 1'b1; shift_left = 1'b0; shift_right = 1'b0;
    tick(3);
    check("rst_idx", int'(phase_idx), 0);
    check("rst_sel", int'(phase_sel), 16'h0001);
    check("rst_locked", int'(locked), 0);
    check("rst_steps", int'(step_left | step_right), 0);
    rst = 1'b0;

    // Lock rises on the 64th enabled cycle after reset release.
    tick(63);
    check("locked_early", int'(locked), 0);
    tick(1);
    check("locked_rise", int'(locked), 1);

    // Right votes held: first step after 2+8, next after 4 holdoff + 8.
    base = cyc; shift_right = 1'b1;
    push(base + 10, 1'b1, 1);
    push(base + 22, 1'b1, 2);
    tick(22);
    shift_right = 1'b0;
    tick(10);

    // Left votes held through the 0 -> 15 wrap.
    base = cyc; shift_left = 1'b1;
    push(base + 10, 1'b0, 1);
    push(base + 22, 1'b0, 0);
    push(base + 34, 1'b0, 15);
    tick(34);
    check("idx_after_left_wrap", int'(phase_idx), 15);
    shift_left = 1'b0;
    tick(10);

    // Right wrap 15 -> 0.
    base = cyc; shift_right = 1'b1;
    push(base + 10, 1'b1, 0);
    tick(10);
    shift_right = 1'b0;
    tick(10);

    // Ambiguous votes must leave acc at 0: a full 8 clean votes still needed.
    shift_left = 1'b1; shift_right = 1'b1;
    tick(30);
    check("idx_after_ambiguous", int'(phase_idx), 0);
    shift_left = 1'b0;
    push(cyc + 10, 1'b1, 1);
    tick(10);
    shift_right = 1'b0;
    tick(70);
    check("locked_before_alt", int'(locked), 1);

    for (int i = 0; i < 100; i++) begin
      shift_right = (i % 2 == 0);
      shift_left  = (i % 2 != 0);
      tick(1);
    end
    shift_left = 1'b0; shift_right = 1'b0;
    tick(5);
    check("locked_after_alt", int'(locked), 1);
    check("idx_after_alt", int'(phase_idx), 1);

    // Enable freeze: 5 votes, 20 frozen cycles, then 3 votes complete the step.
    base = cyc; shift_right = 1'b1;
    tick(7);
    en = 1'b0;
    tick(20);
    check("locked_frozen", int'(locked), 1);
    check("idx_frozen", int'(phase_idx), 1);
    en = 1'b1;
    push(base + 30, 1'b1, 2);
    tick(3);

    // Reset in the cycle after the step, votes still held.
    rst = 1'b1;
    tick(1);
    check("midrst_idx", int'(phase_idx), 0);
    check("midrst_sel", int'(phase_sel), 16'h0001);
    check("midrst_locked", int'(locked), 0);
    rst = 1'b0;
    push(cyc + 10, 1'b1, 1);
    tick(10);
    shift_right = 1'b0;
    tick(10);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
